// File: rtl/glyph_map_filler_if.sv
// Command handshake and map-write bus of the glyph map fill engine.
// master = command source / blanking driver, slave = the fill engine.
interface glyph_map_filler_if #(
    parameter int ID_SIZE    = 6,
    parameter int ADDR_WIDTH = 9
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [4:0]            cmd_x;
    logic [3:0]            cmd_y;
    logic [4:0]            cmd_w;
    logic [3:0]            cmd_h;
    logic [ID_SIZE-1:0]    cmd_id;
    logic                  vblank;
    logic                  write_glyph;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_SIZE-1:0]    glyph_id;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_id, vblank,
        input  cmd_ready, write_glyph, addr, glyph_id, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_id, vblank,
        output cmd_ready, write_glyph, addr, glyph_id, busy, done, err
    );
endinterface

// File: rtl/glyph_map_filler.sv
// Rectangle fill engine: clips a command to the map and writes one glyph per
// clock in row-major order, only while vblank is high.
module glyph_map_filler #(
    parameter int MAP_SIZE_X = 20,
    parameter int MAP_SIZE_Y = 15,
    parameter int ID_SIZE    = 6,
    parameter int ADDR_WIDTH = 9
) (
    input logic               clk,
    input logic               rst,
    glyph_map_filler_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    localparam logic [5:0]            MX6 = 6'(MAP_SIZE_X);
    localparam logic [4:0]            MY5 = 5'(MAP_SIZE_Y);
    localparam logic [ADDR_WIDTH-1:0] MXA = ADDR_WIDTH'(MAP_SIZE_X);

    state_t                r_state;
    logic [5:0]            r_col, r_x0, r_col_last;
    logic [4:0]            r_row, r_row_last;
    logic [ADDR_WIDTH-1:0] r_row_base, r_addr;
    logic [ID_SIZE-1:0]    r_gid;
    logic                  r_busy, r_done, r_err;

    // Clip math is one bit wider than the coordinates so x+w never wraps.
    logic [5:0]            w_x6, w_xsum, w_ew6, w_cl6;
    logic [4:0]            w_y5, w_ysum, w_eh5, w_rl5;
    logic                  w_rej, w_empty;
    logic [ADDR_WIDTH-1:0] w_base, w_start, w_next_base;

    assign w_x6    = {1'b0, bus.cmd_x};
    assign w_y5    = {1'b0, bus.cmd_y};
    assign w_xsum  = w_x6 + {1'b0, bus.cmd_w};
    assign w_ysum  = w_y5 + {1'b0, bus.cmd_h};
    assign w_ew6   = (w_xsum > MX6) ? (MX6 - w_x6) : {1'b0, bus.cmd_w};
    assign w_eh5   = (w_ysum > MY5) ? (MY5 - w_y5) : {1'b0, bus.cmd_h};
    assign w_cl6   = w_x6 + w_ew6 - 6'd1;
    assign w_rl5   = w_y5 + w_eh5 - 5'd1;
    assign w_rej   = (w_x6 >= MX6) || (w_y5 >= MY5);
    assign w_empty = (w_ew6 == 6'd0) || (w_eh5 == 5'd0);

    // The only multiply: row base of the origin, once per accepted command.
    assign w_base      = ADDR_WIDTH'(bus.cmd_y) * MXA;
    assign w_start     = w_base + ADDR_WIDTH'(bus.cmd_x);
    assign w_next_base = r_row_base + MXA;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_x0       <= '0;
            r_col_last <= '0;
            r_row      <= '0;
            r_row_last <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
            r_gid      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_busy <= 1'b1;
                        r_gid  <= bus.cmd_id;
                        if (w_rej || w_empty) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= w_rej;
                        end else begin
                            r_state    <= S_FILL;
                            r_col      <= w_x6;
                            r_x0       <= w_x6;
                            r_col_last <= w_cl6;
                            r_row      <= w_y5;
                            r_row_last <= w_rl5;
                            r_row_base <= w_base;
                            r_addr     <= w_start;
                        end
                    end
                end
                S_FILL: begin
                    // A cell is committed only on an edge where the strobe was up.
                    if (bus.vblank) begin
                        if (r_col == r_col_last) begin
                            if (r_row == r_row_last) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_col      <= r_x0;
                                r_row      <= r_row + 5'd1;
                                r_row_base <= w_next_base;
                                r_addr     <= w_next_base + ADDR_WIDTH'(r_x0);
                            end
                        end else begin
                            r_col  <= r_col + 6'd1;
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (r_state == S_IDLE) && !rst;
    assign bus.write_glyph = (r_state == S_FILL) && bus.vblank;
    assign bus.addr        = r_addr;
    assign bus.glyph_id    = r_gid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_glyph_map_filler.sv
// Directed bench for glyph_map_filler: hand-computed addresses per fill,
// outputs sampled on the falling edge.
module tb_glyph_map_filler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    glyph_map_filler_if #(.ID_SIZE(6), .ADDR_WIDTH(9)) bus ();

    glyph_map_filler #(
        .MAP_SIZE_X(20), .MAP_SIZE_Y(15), .ID_SIZE(6), .ADDR_WIDTH(9)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input logic [4:0] x, input logic [3:0] y, input logic [4:0] w,
                           input logic [3:0] h, input logic [5:0] id);
        bus.cmd_x  = x;
        bus.cmd_y  = y;
        bus.cmd_w  = w;
        bus.cmd_h  = h;
        bus.cmd_id = id;
    endtask

    // Present a command for one edge; returns in the cycle after the accept edge.
    task automatic send(input logic [4:0] x, input logic [3:0] y, input logic [4:0] w,
                        input logic [3:0] h, input logic [5:0] id);
        @(negedge clk);
        chk("ready_before_cmd", bus.cmd_ready, 1);
        set_cmd(x, y, w, h, id);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Walks the writes listed in exp_q, then the done pulse and ready return.
    task automatic expect_fill(input string nm, input logic [5:0] id);
        foreach (exp_q[k]) begin
            chk($sformatf("%s_wr%0d", nm, k), bus.write_glyph, 1);
            chk($sformatf("%s_addr%0d", nm, k), bus.addr, exp_q[k]);
            chk($sformatf("%s_id%0d", nm, k), bus.glyph_id, id);
            chk($sformatf("%s_rdy%0d", nm, k), bus.cmd_ready, 0);
            chk($sformatf("%s_busy%0d", nm, k), bus.busy, 1);
            chk($sformatf("%s_done%0d", nm, k), bus.done, 0);
            @(negedge clk);
        end
        chk({nm, "_done"}, bus.done, 1);
        chk({nm, "_err"}, bus.err, 0);
        chk({nm, "_wr_at_done"}, bus.write_glyph, 0);
        chk({nm, "_rdy_at_done"}, bus.cmd_ready, 0);
        chk({nm, "_busy_at_done"}, bus.busy, 1);
        @(negedge clk);
        chk({nm, "_done_clr"}, bus.done, 0);
        chk({nm, "_rdy_back"}, bus.cmd_ready, 1);
        chk({nm, "_busy_clr"}, bus.busy, 0);
    endtask

    task automatic expect_nofill(input string nm, input logic e);
        chk({nm, "_wr"}, bus.write_glyph, 0);
        chk({nm, "_done"}, bus.done, 1);
        chk({nm, "_err"}, bus.err, e);
        chk({nm, "_rdy"}, bus.cmd_ready, 0);
        @(negedge clk);
        chk({nm, "_done_clr"}, bus.done, 0);
        chk({nm, "_err_clr"}, bus.err, 0);
        chk({nm, "_wr2"}, bus.write_glyph, 0);
        chk({nm, "_rdy_back"}, bus.cmd_ready, 1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.vblank    = 1'b1;
        set_cmd(5'd0, 4'd0, 5'd0, 4'd0, 6'd0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rdy", bus.cmd_ready, 0);
        chk("rst_wr", bus.write_glyph, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_id", bus.glyph_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;
        #1;
        chk("rst_rdy_release", bus.cmd_ready, 1);

        // Basic 3x2 fill at (1,1)
        send(5'd1, 4'd1, 5'd3, 4'd2, 6'h2D);
        exp_q = '{21, 22, 23, 41, 42, 43};
        expect_fill("basic", 6'h2D);

        // Clipped at the bottom-right corner
        send(5'd18, 4'd14, 5'd5, 4'd3, 6'h01);
        exp_q = '{298, 299};
        expect_fill("clip", 6'h01);

        // Rejections and empty command
        send(5'd20, 4'd0, 5'd1, 4'd1, 6'h11);
        expect_nofill("rej_x", 1'b1);
        send(5'd0, 4'd15, 5'd1, 4'd1, 6'h12);
        expect_nofill("rej_y", 1'b1);
        send(5'd0, 4'd0, 5'd0, 4'd1, 6'h13);
        expect_nofill("empty_w", 1'b0);

        // Blanking pause after the second write
        send(5'd0, 4'd0, 5'd4, 4'd1, 6'h22);
        chk("pause_a0", bus.addr, 0);
        chk("pause_w0", bus.write_glyph, 1);
        @(negedge clk);
        chk("pause_a1", bus.addr, 1);
        chk("pause_w1", bus.write_glyph, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.vblank = 1'b0;
            #1;
            chk($sformatf("pause_gap_wr%0d", i), bus.write_glyph, 0);
            chk($sformatf("pause_gap_addr%0d", i), bus.addr, 2);
            chk($sformatf("pause_gap_busy%0d", i), bus.busy, 1);
        end
        @(negedge clk);
        bus.vblank = 1'b1;
        #1;
        exp_q = '{2, 3};
        expect_fill("pause", 6'h22);

        // Back-to-back: valid held, second command loaded during the first fill
        @(negedge clk);
        set_cmd(5'd0, 4'd0, 5'd2, 4'd1, 6'h05);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        set_cmd(5'd5, 4'd2, 5'd1, 4'd1, 6'h3F);
        chk("b2b_a0", bus.addr, 0);
        chk("b2b_id0", bus.glyph_id, 6'h05);
        chk("b2b_rdy0", bus.cmd_ready, 0);
        @(negedge clk);
        chk("b2b_a1", bus.addr, 1);
        chk("b2b_rdy1", bus.cmd_ready, 0);
        @(negedge clk);
        chk("b2b_done1", bus.done, 1);
        chk("b2b_rdy_done", bus.cmd_ready, 0);
        @(negedge clk);
        chk("b2b_rdy_idle", bus.cmd_ready, 1);
        chk("b2b_wr_idle", bus.write_glyph, 0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        exp_q = '{45};
        expect_fill("b2b_2nd", 6'h3F);

        // Reset in the middle of a 10-cell fill
        send(5'd0, 4'd3, 5'd10, 4'd1, 6'h07);
        chk("mid_a0", bus.addr, 60);
        repeat (3) @(negedge clk);
        chk("mid_a3", bus.addr, 63);
        rst = 1'b1;
        #1;
        chk("mid_rdy_in_rst", bus.cmd_ready, 0);
        @(negedge clk);
        chk("mid_wr", bus.write_glyph, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_rdy", bus.cmd_ready, 0);
        chk("mid_done", bus.done, 0);
        rst = 1'b0;
        #1;
        chk("mid_rdy_release", bus.cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mid_nodone%0d", i), bus.done, 0);
            chk($sformatf("mid_nowr%0d", i), bus.write_glyph, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/glyph_map_filler.md
# glyph_map_filler

Rectangle-fill engine for the background glyph map. It accepts one fill command at a time: a map origin, a width, a height and a 6-bit glyph id. It then issues one glyph-map write per clock onto the background controller's write port (`write_glyph`, `addr`, `glyph_id`), visiting the clipped rectangle in row-major order. Writes are issued only while `vblank` is high, so map updates never tear a visible frame.

## Interface

Parameters
- `MAP_SIZE_X`, 20: map width in glyphs.
- `MAP_SIZE_Y`, 15: map height in glyphs.
- `ID_SIZE`, 6: glyph id width. Bits [1:0] are rotation, [3:2] the sheet column, [5:4] the sheet row. The id is passed through unmodified.
- `ADDR_WIDTH`, 9: map address width; must hold `MAP_SIZE_X*MAP_SIZE_Y-1`.

Ports
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine can accept a command.
- `cmd_x` in 5: origin column.
- `cmd_y` in 4: origin row.
- `cmd_w` in 5: width in glyphs (0–31).
- `cmd_h` in 4: height in glyphs (0–15).
- `cmd_id` in `ID_SIZE`: glyph id to write.
- `vblank` in 1: high while the display is in vertical blanking.
- `write_glyph` out 1: map write strobe, to the background controller.
- `addr` out `ADDR_WIDTH`: map address, `row*MAP_SIZE_X + col`.
- `glyph_id` out `ID_SIZE`: id being written.
- `busy` out 1: high in FILL and DONE.
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: one-cycle pulse when a command is rejected.

## Operation

- States: IDLE, FILL, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - A handshake is `cmd_valid & cmd_ready` at a rising edge.
  - On a handshake, inputs are latched and clipped:
    - `ew = min(cmd_w, MAP_SIZE_X-cmd_x)`.
    - `eh = min(cmd_h, MAP_SIZE_Y-cmd_y)`.
  - `cmd_x >= MAP_SIZE_X` or `cmd_y >= MAP_SIZE_Y`: go to DONE with `err` set; no writes.
  - `ew==0` or `eh==0` (in-range origin): go to DONE, no writes, no `err`.
  - Otherwise: go to FILL with `col=cmd_x`, `row=cmd_y`, `row_base=cmd_y*MAP_SIZE_X`.
    - This multiply is done once per command.
    - `row_base` advances by adding `MAP_SIZE_X` per row; there is no per-cell multiply.
- **FILL**
  - `addr = row_base + col`, `glyph_id` = latched id. Both are registered and stable during FILL.
  - `write_glyph = vblank` (combinational gate on the registered state).
  - At each edge with `vblank`=1, the cell is committed by the controller and the engine advances:
    - `col+1`.
    - At the row end (`col == cmd_x+ew-1`): `col=cmd_x`, `row+1`, `row_base += MAP_SIZE_X`.
    - After the last cell: go to DONE.
  - At an edge with `vblank`=0: no change. Fill pauses and resumes at the same cell.
- **DONE**
  - `done`=1 for exactly one cycle.
  - `err`=1 in the same cycle if the command was rejected.
  - `cmd_ready`=0.
  - Next edge: IDLE.
- `cmd_*` are ignored outside an IDLE handshake. Changes to them during FILL have no effect.

## Timing

- Reset values:
  - state IDLE.
  - `cmd_ready`=1 (forced 0 while `rst` is high).
  - `write_glyph`=0, `addr`=0, `glyph_id`=0, `busy`=0, `done`=0, `err`=0.
- Throughput: one write per clock while `vblank`=1.
- For a command accepted at edge N with `vblank` held high:
  - The k-th write (k=0..n-1, n=`ew*eh`) is visible in the cycle after edge N+k and committed at edge N+k+1.
  - `done` is high in the cycle after edge N+n.
  - `cmd_ready` returns after edge N+n+1.
- A rejected or empty command accepted at edge N gives `done` (and `err` if rejected) in the cycle after edge N.
- `rst` during FILL aborts the fill immediately.
  - Cells already written remain written.
  - `write_glyph` is 0 in the cycle following the reset edge.
  - No `done` is issued.
- All arithmetic is unsigned.
  - Clip compares use the widened sum `cmd_x+cmd_w` (6 bits) so nothing wraps.
  - `addr` never exceeds `MAP_SIZE_X*MAP_SIZE_Y-1`.

## Test plan

- **Basic fill.** Inputs: `vblank`=1; command x=1, y=1, w=3, h=2, id=0x2D.
  - Required: writes to addr 21, 22, 23, 41, 42, 43 in consecutive cycles, all with `glyph_id`=0x2D.
  - Required: `done` pulse one cycle after the last write; `cmd_ready` high the cycle after that.
- **Clipping.** Command x=18, y=14, w=5, h=3, id=0x01.
  - Required: exactly two writes, addr 298 then 299; `done` set, `err` clear.
- **Rejection.** Command x=20, y=0, w=1, h=1.
  - Required: no `write_glyph`; `done` and `err` both high for one cycle, the cycle after accept.
  - Repeat with w=0 at x=0: `done` pulse, `err`=0, no writes.
- **Blanking pause.** Command x=0, y=0, w=4, h=1; drop `vblank` for 3 cycles after the second write.
  - Required: `write_glyph`=0 and `addr` held at 2 during the gap; writes resume at addr 2 then 3; no address skipped or duplicated.
- **Back-to-back.** Hold `cmd_valid` high with a second command.
  - Required: the second command is accepted only on the edge after DONE; `cmd_ready` stays 0 throughout FILL and DONE.
- **Reset mid-fill.** Assert `rst` after 3 writes of a 10-cell fill.
  - Required: the next cycle shows `write_glyph`=0, `busy`=0, `cmd_ready`=0 while `rst` is high and 1 after it drops; no `done`.
